// File: rtl/frame_deserializer.sv
// Sync-hunting UART frame deserializer with inter-byte timeout and a valid/ready output holding register.
// Define FRAME_DESER_CHECKSUM_EN to expect a trailing XOR checksum byte after each payload.

module uart_receive #(
  parameter int unsigned BAUD_RATE        = 9600,
  parameter int unsigned INPUT_CLOCK_FREQ = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] data
);
  localparam int unsigned PERIOD = INPUT_CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned CW     = $clog2(PERIOD + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, BITS = 2'd2, STOP = 2'd3} rx_state_t;

  rx_state_t      state;
  logic [1:0]     rx_sync;
  logic [CW-1:0]  cnt;
  logic [2:0]     bitn;
  logic [7:0]     shreg;
  logic           rx_s;

  assign rx_s = rx_sync[1];

  // Samples each bit at its centre, timed from the start-bit falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rx_sync    <= 2'b11;
      cnt        <= '0;
      bitn       <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      data       <= '0;
    end else begin
      rx_sync    <= {rx_sync[0], rx};
      byte_valid <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (cnt == CW'(PERIOD / 2 - 1)) begin
            cnt   <= '0;
            bitn  <= '0;
            state <= rx_s ? IDLE : BITS;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        BITS: begin
          if (cnt == CW'(PERIOD - 1)) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[7:1]};
            if (bitn == 3'd7) state <= STOP;
            bitn <= bitn + 3'd1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt == CW'(PERIOD - 1)) begin
            cnt   <= '0;
            state <= IDLE;
            if (rx_s) begin
              byte_valid <= 1'b1;
              data       <= shreg;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

module frame_deserializer #(
  parameter int unsigned FRAME_BYTES      = 10,
  parameter int unsigned BAUD_RATE        = 9600,
  parameter int unsigned INPUT_CLOCK_FREQ = 100_000_000,
  parameter logic [7:0]  SYNC_BYTE        = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES   = 200_000,
  parameter int unsigned LSB_FIRST        = 1
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rx_wire_in,
  input  logic                     ready_in,
  output logic                     valid_out,
  output logic [8*FRAME_BYTES-1:0] data_out,
  output logic                     err_timeout_out,
  output logic                     err_overrun_out,
  output logic                     err_checksum_out
);
  localparam int unsigned DW = 8 * FRAME_BYTES;
  localparam int unsigned IW = $clog2(FRAME_BYTES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

`ifdef FRAME_DESER_CHECKSUM_EN
  typedef enum logic [1:0] {HUNT = 2'd0, COLLECT = 2'd1, CHECK = 2'd2} state_t;
`else
  typedef enum logic [1:0] {HUNT = 2'd0, COLLECT = 2'd1} state_t;
`endif

  state_t         state;
  logic           byte_valid;
  logic [7:0]     rx_byte;
  logic [IW-1:0]  index;
  logic [IW-1:0]  slot;
  logic [TW-1:0]  tcnt;
  logic [DW-1:0]  buffer;
  logic [DW-1:0]  next_buf;
  logic [DW-1:0]  frame_data;
  logic           frame_done;
  logic           last_byte;
  logic           timed_out;
`ifdef FRAME_DESER_CHECKSUM_EN
  logic [7:0]     csum;
`endif

  uart_receive #(
    .BAUD_RATE        (BAUD_RATE),
    .INPUT_CLOCK_FREQ (INPUT_CLOCK_FREQ)
  ) u_rx (
    .clk        (clk_in),
    .rst        (rst_in),
    .rx         (rx_wire_in),
    .byte_valid (byte_valid),
    .data       (rx_byte)
  );

  assign last_byte = (index == IW'(FRAME_BYTES - 1));
  assign timed_out = (tcnt == TW'(TIMEOUT_CYCLES - 1));

  // Buffer with the incoming byte merged into its byte-order slot.
  always_comb begin
    slot     = (LSB_FIRST != 0) ? index : IW'(FRAME_BYTES - 1) - index;
    next_buf = buffer;
    for (int i = 0; i < int'(FRAME_BYTES); i++) begin
      if (slot == IW'(i)) next_buf[8*i +: 8] = rx_byte;
    end
  end

  // Frame completion strobe and the payload it delivers.
  always_comb begin
    frame_done = 1'b0;
    frame_data = next_buf;
    case (state)
`ifdef FRAME_DESER_CHECKSUM_EN
      CHECK: begin
        frame_data = buffer;
        frame_done = byte_valid && (rx_byte == csum);
      end
`else
      COLLECT: frame_done = byte_valid && last_byte;
`endif
      default: frame_done = 1'b0;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state            <= HUNT;
      index            <= '0;
      tcnt             <= '0;
      buffer           <= '0;
      valid_out        <= 1'b0;
      data_out         <= '0;
      err_timeout_out  <= 1'b0;
      err_overrun_out  <= 1'b0;
`ifdef FRAME_DESER_CHECKSUM_EN
      csum             <= '0;
      err_checksum_out <= 1'b0;
`endif
    end else begin
      err_timeout_out <= 1'b0;
      err_overrun_out <= 1'b0;
`ifdef FRAME_DESER_CHECKSUM_EN
      err_checksum_out <= 1'b0;
`endif
      if (valid_out && ready_in) valid_out <= 1'b0;

      case (state)
        HUNT: begin
          if (byte_valid && (rx_byte == SYNC_BYTE)) begin
            index  <= '0;
            buffer <= '0;
            tcnt   <= '0;
`ifdef FRAME_DESER_CHECKSUM_EN
            csum   <= '0;
`endif
            state  <= COLLECT;
          end
        end
        COLLECT: begin
          if (byte_valid) begin
            buffer <= next_buf;
            tcnt   <= '0;
`ifdef FRAME_DESER_CHECKSUM_EN
            csum   <= csum ^ rx_byte;
`endif
            if (last_byte) begin
              index <= '0;
`ifdef FRAME_DESER_CHECKSUM_EN
              state <= CHECK;
`else
              state <= HUNT;
`endif
            end else begin
              index <= index + IW'(1);
            end
          end else if (timed_out) begin
            err_timeout_out <= 1'b1;
            state           <= HUNT;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
`ifdef FRAME_DESER_CHECKSUM_EN
        CHECK: begin
          if (byte_valid) begin
            if (rx_byte != csum) err_checksum_out <= 1'b1;
            state <= HUNT;
          end else if (timed_out) begin
            err_timeout_out <= 1'b1;
            state           <= HUNT;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
`endif
        default: state <= HUNT;
      endcase

      // A frame either loads into the free/freeing holding register or is dropped.
      if (frame_done) begin
        if (!valid_out || ready_in) begin
          data_out  <= frame_data;
          valid_out <= 1'b1;
        end else begin
          err_overrun_out <= 1'b1;
        end
      end
    end
  end

`ifndef FRAME_DESER_CHECKSUM_EN
  assign err_checksum_out = 1'b0;
`endif
endmodule

// File: tb/tb_frame_deserializer.sv
// Directed bench for frame_deserializer: two instances (LSB-first and MSB-first) share one RX line.
module tb_frame_deserializer;
  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic        ready;
  logic        valid_a, valid_b;
  logic [23:0] data_a, data_b;
  logic        to_a, ov_a, ck_a, to_b, ov_b, ck_b;

  int n_checks = 0;
  int n_pass   = 0;

  int acc_a = 0, acc_b = 0, vcyc_a = 0, to_cnt = 0, ov_cnt = 0, ck_cnt = 0;
  logic [23:0] cap_a = '0, cap_b = '0;
  int b_acc_a, b_acc_b, b_vcyc_a, b_to, b_ov, b_ck;

  always #5 clk = ~clk;

  frame_deserializer #(
    .FRAME_BYTES(3), .BAUD_RATE(6_250_000), .INPUT_CLOCK_FREQ(100_000_000),
    .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(400), .LSB_FIRST(1)
  ) dut_a (
    .clk_in(clk), .rst_in(rst), .rx_wire_in(rx), .ready_in(ready),
    .valid_out(valid_a), .data_out(data_a), .err_timeout_out(to_a),
    .err_overrun_out(ov_a), .err_checksum_out(ck_a)
  );

  frame_deserializer #(
    .FRAME_BYTES(3), .BAUD_RATE(6_250_000), .INPUT_CLOCK_FREQ(100_000_000),
    .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(400), .LSB_FIRST(0)
  ) dut_b (
    .clk_in(clk), .rst_in(rst), .rx_wire_in(rx), .ready_in(ready),
    .valid_out(valid_b), .data_out(data_b), .err_timeout_out(to_b),
    .err_overrun_out(ov_b), .err_checksum_out(ck_b)
  );

  // Event counters sampled on the falling edge.
  always @(negedge clk) begin
    if (valid_a && ready) begin acc_a++; cap_a = data_a; end
    if (valid_b && ready) begin acc_b++; cap_b = data_b; end
    if (valid_a) vcyc_a++;
    if (to_a) to_cnt++;
    if (ov_a) ov_cnt++;
    if (ck_a) ck_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic mark();
    b_acc_a = acc_a; b_acc_b = acc_b; b_vcyc_a = vcyc_a;
    b_to = to_cnt; b_ov = ov_cnt; b_ck = ck_cnt;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk) rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (16) @(negedge clk);
    end
    rx = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  // Sends sync + three payload bytes, plus the XOR byte when checksums are built in.
  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(8'hA5);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
`ifdef FRAME_DESER_CHECKSUM_EN
    send_byte(b0 ^ b1 ^ b2);
`endif
    repeat (20) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; rx = 1'b1; ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_valid", 32'(valid_a), 32'h0);
    check("reset_data", 32'(data_a), 32'h0);
    check("reset_errs", 32'({to_a, ov_a, ck_a}), 32'h0);

    // Basic frame with leading junk byte
    mark();
    send_byte(8'h5A);
    send_frame(8'h11, 8'h22, 8'h33);
    check("basic_accept", 32'(acc_a - b_acc_a), 32'd1);
    check("basic_data_lsb", 32'(cap_a), 32'h332211);
    check("basic_data_msb", 32'(cap_b), 32'h112233);
    check("basic_valid_cycles", 32'(vcyc_a - b_vcyc_a), 32'd1);
    check("basic_errs", 32'((to_cnt - b_to) + (ov_cnt - b_ov) + (ck_cnt - b_ck)), 32'd0);

    // Sync value as payload data, both byte orders
    mark();
    send_frame(8'hA5, 8'h01, 8'h02);
    check("order_msb", 32'(cap_b), 32'hA50102);
    check("order_lsb", 32'(cap_a), 32'h0201A5);
    check("order_accept_b", 32'(acc_b - b_acc_b), 32'd1);

    // Backpressure: second frame overruns the held first frame
    @(posedge clk); #1 ready = 1'b0;
    mark();
    send_frame(8'h11, 8'h22, 8'h33);
    send_frame(8'h44, 8'h55, 8'h66);
    check("bp_valid", 32'(valid_a), 32'h1);
    check("bp_data_held", 32'(data_a), 32'h332211);
    check("bp_data_held_msb", 32'(data_b), 32'h112233);
    check("bp_overrun", 32'(ov_cnt - b_ov), 32'd1);
    @(posedge clk); #1 ready = 1'b1;
    @(negedge clk);
    check("bp_valid_before_accept", 32'(valid_a), 32'h1);
    @(negedge clk);
    check("bp_valid_after_accept", 32'(valid_a), 32'h0);

    // Inter-byte timeout aborts a partial frame
    mark();
    send_byte(8'hA5);
    send_byte(8'h11);
    repeat (450) @(negedge clk);
    check("timeout_pulse", 32'(to_cnt - b_to), 32'd1);
    check("timeout_no_frame", 32'(acc_a - b_acc_a), 32'd0);
    mark();
    send_frame(8'h77, 8'h88, 8'h99);
    check("after_timeout_data", 32'(cap_a), 32'h998877);
    check("after_timeout_accept", 32'(acc_a - b_acc_a), 32'd1);
    check("after_timeout_no_err", 32'(to_cnt - b_to), 32'd0);

`ifdef FRAME_DESER_CHECKSUM_EN
    // Bad then good checksum
    mark();
    send_byte(8'hA5); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h01);
    repeat (20) @(negedge clk);
    check("cksum_bad_pulse", 32'(ck_cnt - b_ck), 32'd1);
    check("cksum_bad_no_frame", 32'(acc_a - b_acc_a), 32'd0);
    mark();
    send_frame(8'h11, 8'h22, 8'h33);
    check("cksum_good_accept", 32'(acc_a - b_acc_a), 32'd1);
    check("cksum_good_data", 32'(cap_a), 32'h332211);
    check("cksum_good_no_err", 32'(ck_cnt - b_ck), 32'd0);
`endif

    // Reset mid-frame discards the partial frame and held data
    send_byte(8'hA5);
    send_byte(8'h11);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", 32'(valid_a), 32'h0);
    check("rst_mid_data", 32'(data_a), 32'h0);
    check("rst_mid_data_msb", 32'(data_b), 32'h0);
    mark();
    send_frame(8'hAA, 8'hBB, 8'hCC);
    check("post_rst_data", 32'(cap_a), 32'hCCBBAA);
    check("post_rst_data_msb", 32'(cap_b), 32'hAABBCC);
    check("post_rst_accept", 32'(acc_a - b_acc_a), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
